// File: rtl/srl32_fifo_ctrl.sv
// First-word-fall-through FIFO on 32-deep addressable shift-register slices.
// Occupancy and tap address are tracked so the oldest word sits on o_data_out.
module srl32_slice (
  input  logic       i_clk,
  input  logic       i_ce,
  input  logic       i_d,
  input  logic [4:0] i_a,
  output logic       o_q
);

  logic [31:0] r_data;

  // No reset: contents are masked by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_ce)
      r_data <= {r_data[30:0], i_d};
  end

  assign o_q = r_data[i_a];

endmodule

module srl32_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_write,
  input  logic             i_read,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_present,
  output logic             o_half_full,
  output logic             o_full,
  output logic [5:0]       o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic [5:0] LP_FULL = 6'(DEPTH);
  localparam logic [5:0] LP_HALF = 6'(DEPTH / 2);

  logic [5:0] r_count;
  logic [4:0] r_addr;
  logic       r_present;
  logic       r_half;
  logic       r_full;
  logic       r_ovf;
  logic       r_unf;

  logic       w_wr_acc;
  logic       w_rd_acc;
  logic       w_push;
  logic       w_pop;
  logic       w_ce;
  logic [5:0] w_cnt_nxt;
  logic [4:0] w_addr_nxt;

  assign w_wr_acc = i_write & (~r_full | i_read);
  assign w_rd_acc = i_read & r_present;
  assign w_push   = w_wr_acc & ~w_rd_acc;
  assign w_pop    = w_rd_acc & ~w_wr_acc;
  assign w_ce     = w_wr_acc & ~i_rst;

  always_comb begin
    w_cnt_nxt  = r_count;
    w_addr_nxt = r_addr;
    unique case (1'b1)
      w_push: begin
        w_cnt_nxt  = r_count + 6'd1;
        w_addr_nxt = (r_count == 6'd0) ? 5'd0 : r_addr + 5'd1;
      end
      w_pop: begin
        w_cnt_nxt  = r_count - 6'd1;
        w_addr_nxt = (r_count == 6'd1) ? 5'd0 : r_addr - 5'd1;
      end
      default: begin
        w_cnt_nxt  = r_count;
        w_addr_nxt = r_addr;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= 6'd0;
      r_addr    <= 5'd0;
      r_present <= 1'b0;
      r_half    <= 1'b0;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_count   <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_present <= (w_cnt_nxt != 6'd0);
      r_half    <= (w_cnt_nxt >= LP_HALF);
      r_full    <= (w_cnt_nxt == LP_FULL);
      if (i_write & r_full & ~i_read)
        r_ovf <= 1'b1;
      if (i_read & ~r_present)
        r_unf <= 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_slice
    srl32_slice u_slice (
      .i_clk (i_clk),
      .i_ce  (w_ce),
      .i_d   (i_data_in[g]),
      .i_a   (r_addr),
      .o_q   (o_data_out[g])
    );
  end

  assign o_data_present = r_present;
  assign o_half_full    = r_half;
  assign o_full         = r_full;
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_unf;

endmodule

// File: tb/tb_srl32_fifo_ctrl.sv
// Directed bench for srl32_fifo_ctrl: ordering, flags, boundaries, reset.
module tb_srl32_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] dout;
  logic       present;
  logic       half;
  logic       full;
  logic [5:0] count;
  logic       ovf;
  logic       unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srl32_fifo_ctrl #(.WIDTH(8), .DEPTH(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_data_in      (din),
    .i_write        (wr),
    .i_read         (rd),
    .o_data_out     (dout),
    .o_data_present (present),
    .o_half_full    (half),
    .o_full         (full),
    .o_count        (count),
    .o_overflow     (ovf),
    .o_underflow    (unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    // 1: reset state, three writes, three reads
    rst = 1'b1;
    cyc(0, 0, 8'h00);
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_present", present, 0);
    chk("rst_half", half, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    cyc(1, 0, 8'h11);
    chk("t1_present1", present, 1);
    chk("t1_dout1", dout, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 0, 8'h33);
    chk("t1_count3", count, 3);
    chk("t1_dout", dout, 8'h11);
    cyc(0, 1, 8'h00);
    chk("t1_rd1", dout, 8'h22);
    cyc(0, 1, 8'h00);
    chk("t1_rd2", dout, 8'h33);
    cyc(0, 1, 8'h00);
    chk("t1_empty", present, 0);
    chk("t1_count0", count, 0);

    // 2: fill to 32, overflow, drain
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 8'(i));
      chk("t2_count", count, i + 1);
      chk("t2_half", half, (i + 1 >= 16) ? 1 : 0);
      chk("t2_full", full, (i + 1 == 32) ? 1 : 0);
      chk("t2_head", dout, 8'h00);
    end
    chk("t2_ovf_pre", ovf, 0);
    cyc(1, 0, 8'hAA);
    chk("t2_ovf", ovf, 1);
    chk("t2_cnt_ovf", count, 32);
    chk("t2_full_ovf", full, 1);
    for (int i = 0; i < 32; i++) begin
      chk("t2_drain", dout, 8'(i));
      cyc(0, 1, 8'h00);
    end
    chk("t2_empty", present, 0);
    chk("t2_half_e", half, 0);
    chk("t2_ovf_sticky", ovf, 1);

    // 3: simultaneous write/read while full
    for (int i = 0; i < 32; i++)
      cyc(1, 0, 8'(i));
    chk("t3_full_pre", full, 1);
    chk("t3_dout_pre", dout, 8'h00);
    cyc(1, 1, 8'h55);
    chk("t3_count", count, 32);
    chk("t3_full", full, 1);
    chk("t3_dout", dout, 8'h01);
    for (int i = 1; i < 32; i++) begin
      chk("t3_drain", dout, 8'(i));
      cyc(0, 1, 8'h00);
    end
    chk("t3_last", dout, 8'h55);
    cyc(0, 1, 8'h00);
    chk("t3_empty", present, 0);

    // 4: read+write on empty
    chk("t4_unf_pre", unf, 0);
    cyc(1, 1, 8'h7E);
    chk("t4_unf", unf, 1);
    chk("t4_count", count, 1);
    chk("t4_dout", dout, 8'h7E);
    chk("t4_present", present, 1);
    cyc(0, 1, 8'h00);
    chk("t4_empty", count, 0);

    // 5: steady state at COUNT=5
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 8'(i));
    for (int k = 0; k < 100; k++) begin
      chk("t5_order", dout, 8'(k));
      cyc(1, 1, 8'(k + 5));
      chk("t5_count", count, 5);
    end
    for (int k = 100; k < 105; k++) begin
      chk("t5_tail", dout, 8'(k));
      cyc(0, 1, 8'h00);
    end
    chk("t5_empty", present, 0);

    // 6: reset during write with 20 words and overflow set
    for (int i = 0; i < 20; i++)
      cyc(1, 0, 8'(8'h80 + i));
    chk("t6_count20", count, 20);
    chk("t6_half", half, 1);
    chk("t6_ovf", ovf, 1);
    rst = 1'b1;
    cyc(1, 0, 8'h99);
    rst = 1'b0;
    chk("t6_count", count, 0);
    chk("t6_present", present, 0);
    chk("t6_half0", half, 0);
    chk("t6_full", full, 0);
    chk("t6_ovf0", ovf, 0);
    chk("t6_unf0", unf, 0);
    cyc(1, 0, 8'h3C);
    chk("t6_dout", dout, 8'h3C);
    chk("t6_count1", count, 1);
    cyc(0, 1, 8'h00);
    chk("t6_empty", present, 0);
    chk("t6_unf_keep", unf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
